// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris gravity scheduler.
package tetris_pkg;

  typedef enum logic [1:0] {
    SCH_IDLE  = 2'd0,
    SCH_RUN   = 2'd1,
    SCH_PAUSE = 2'd2
  } sch_state_e;

  localparam int LEVEL_W = 4;
  localparam int LINES_W = 3;

  // Production defaults for the gravity timing
  localparam int DEF_CNT_W           = 26;
  localparam int DEF_BASE_PERIOD     = 2500000;
  localparam int DEF_LEVEL_STEP      = 200000;
  localparam int DEF_MIN_PERIOD      = 250000;
  localparam int DEF_SOFT_PERIOD     = 125000;
  localparam int DEF_LINES_PER_LEVEL = 10;
  localparam int DEF_MAX_LEVEL       = 15;

  // A single lock can clear at most four lines; larger reports are clamped
  localparam logic [LINES_W-1:0] MAX_LINES_PER_LOCK = 3'd4;

  function automatic logic [LINES_W-1:0] clamp_lines(input logic [LINES_W-1:0] n);
    if (n > MAX_LINES_PER_LOCK) begin
      clamp_lines = MAX_LINES_PER_LOCK;
    end else begin
      clamp_lines = n;
    end
  endfunction

endpackage

// File: rtl/tick_period_counter.sv
// Free-running period counter: counts while enabled, emits a registered
// one-cycle tick when the count reaches period-1, holds when disabled.
module tick_period_counter #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick_q;
  logic             tick_d;
  logic             hit_s;

  // Next count and tick; ">=" lets a period that shrank mid-count fire at once
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    hit_s  = (cnt_q >= (period_i - CNT_W'(1)));
    if (clr_i) begin
      cnt_d  = {CNT_W{1'b0}};
      tick_d = 1'b0;
    end else if (en_i) begin
      if (hit_s) begin
        cnt_d  = {CNT_W{1'b0}};
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
      end
    end else begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
    end
  end

  // Count and tick registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= {CNT_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/gravity_tick_scheduler.sv
// Gravity clock for the Tetris core: run/pause/stop FSM, level and line
// accounting, level-dependent period selection and the drop_tick counter.
module gravity_tick_scheduler
  import tetris_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int BASE_PERIOD     = DEF_BASE_PERIOD,
  parameter int LEVEL_STEP      = DEF_LEVEL_STEP,
  parameter int MIN_PERIOD      = DEF_MIN_PERIOD,
  parameter int SOFT_PERIOD     = DEF_SOFT_PERIOD,
  parameter int LINES_PER_LEVEL = DEF_LINES_PER_LEVEL,
  parameter int MAX_LEVEL       = DEF_MAX_LEVEL
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause_toggle,
  input  logic               soft_drop,
  input  logic               lines_valid,
  input  logic [LINES_W-1:0] lines_add,
  output logic               drop_tick,
  output logic               level_up,
  output logic [LEVEL_W-1:0] level,
  output logic [CNT_W-1:0]   period,
  output logic               running,
  output logic               paused
);

  // Extra headroom so base - level*step can be evaluated without overflow
  localparam int EXT_W = CNT_W + 4;
  localparam int ACC_W = $clog2(LINES_PER_LEVEL + 4);

  localparam logic [EXT_W-1:0] BASE_X = EXT_W'(BASE_PERIOD);
  localparam logic [EXT_W-1:0] STEP_X = EXT_W'(LEVEL_STEP);
  localparam logic [EXT_W-1:0] MIN_X  = EXT_W'(MIN_PERIOD);
  localparam logic [EXT_W-1:0] SOFT_X = EXT_W'(SOFT_PERIOD);

  sch_state_e         state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               level_up_q, level_up_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               running_q, paused_q;

  logic               restart_s;
  logic               lines_ok_s;
  logic               cnt_en_s;
  logic               cnt_clr_s;
  logic [ACC_W-1:0]   sum_s;
  logic [EXT_W-1:0]   prod_s;
  logic [EXT_W-1:0]   diff_s;
  logic [EXT_W-1:0]   lvl_per_s;

  // Control FSM next state: stop beats start, start beats pause_toggle
  always_comb begin
    state_d = state_q;
    case (state_q)
      SCH_IDLE: begin
        if (stop)       state_d = SCH_IDLE;
        else if (start) state_d = SCH_RUN;
        else            state_d = SCH_IDLE;
      end
      SCH_RUN: begin
        if (stop)              state_d = SCH_IDLE;
        else if (start)        state_d = SCH_RUN;
        else if (pause_toggle) state_d = SCH_PAUSE;
        else                   state_d = SCH_RUN;
      end
      SCH_PAUSE: begin
        if (stop)              state_d = SCH_IDLE;
        else if (start)        state_d = SCH_RUN;
        else if (pause_toggle) state_d = SCH_RUN;
        else                   state_d = SCH_PAUSE;
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  // Qualifiers: a restart wipes the game; counting needs RUN now and next cycle
  always_comb begin
    restart_s  = start & ~stop;
    lines_ok_s = (state_q == SCH_RUN) & ~stop & ~restart_s;
    cnt_en_s   = (state_q == SCH_RUN) & (state_d == SCH_RUN) & ~restart_s;
    cnt_clr_s  = restart_s | (state_d == SCH_IDLE);
  end

  // Line accumulator and saturating level counter
  always_comb begin
    level_d    = level_q;
    acc_d      = acc_q;
    level_up_d = 1'b0;
    sum_s      = acc_q + ACC_W'(clamp_lines(lines_add));
    if (restart_s) begin
      level_d = {LEVEL_W{1'b0}};
      acc_d   = {ACC_W{1'b0}};
    end else if (lines_ok_s && lines_valid) begin
      if (sum_s >= ACC_W'(LINES_PER_LEVEL)) begin
        acc_d = sum_s - ACC_W'(LINES_PER_LEVEL);
        if (level_q < LEVEL_W'(MAX_LEVEL)) begin
          level_d    = level_q + LEVEL_W'(1);
          level_up_d = 1'b1;
        end else begin
          level_d    = level_q;
          level_up_d = 1'b0;
        end
      end else begin
        acc_d = sum_s;
      end
    end else begin
      level_d = level_q;
      acc_d   = acc_q;
    end
  end

  // Period selection: level period floored at MIN, soft drop never slows gravity
  always_comb begin
    prod_s = EXT_W'(level_q) * STEP_X;
    diff_s = BASE_X - prod_s;
    if (prod_s > BASE_X) begin
      lvl_per_s = MIN_X;
    end else if (diff_s < MIN_X) begin
      lvl_per_s = MIN_X;
    end else begin
      lvl_per_s = diff_s;
    end
    if (soft_drop && (SOFT_X < lvl_per_s)) begin
      period_d = CNT_W'(SOFT_X);
    end else begin
      period_d = CNT_W'(lvl_per_s);
    end
  end

  // State, level, accumulator and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SCH_IDLE;
      level_q    <= {LEVEL_W{1'b0}};
      acc_q      <= {ACC_W{1'b0}};
      level_up_q <= 1'b0;
      period_q   <= CNT_W'(BASE_PERIOD);
      running_q  <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      level_q    <= level_d;
      acc_q      <= acc_d;
      level_up_q <= level_up_d;
      period_q   <= period_d;
      running_q  <= (state_d == SCH_RUN);
      paused_q   <= (state_d == SCH_PAUSE);
    end
  end

  tick_period_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .en_i     (cnt_en_s),
    .clr_i    (cnt_clr_s),
    .period_i (period_q),
    .tick_o   (drop_tick)
  );

  assign level_up = level_up_q;
  assign level    = level_q;
  assign period   = period_q;
  assign running  = running_q;
  assign paused   = paused_q;

endmodule

// File: tb/tb_gravity_tick_scheduler.sv
// Self-checking bench for gravity_tick_scheduler with small test periods.
module tb_gravity_tick_scheduler;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start, stop, pause_toggle, soft_drop, lines_valid;
  logic [2:0]    lines_add;
  logic          drop_tick, level_up, running, paused;
  logic [3:0]    level;
  logic [CW-1:0] period;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit tick_chk;
  int exp_q[$];

  typedef struct {
    logic [2:0] lines;
    int         lvl;
    int         up;
    int         per;
  } vec_t;
  vec_t tbl[12];

  always #5 clk = ~clk;

  gravity_tick_scheduler #(
    .CNT_W(CW), .BASE_PERIOD(20), .LEVEL_STEP(4), .MIN_PERIOD(6),
    .SOFT_PERIOD(3), .LINES_PER_LEVEL(10), .MAX_LEVEL(15)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
    .pause_toggle(pause_toggle), .soft_drop(soft_drop),
    .lines_valid(lines_valid), .lines_add(lines_add),
    .drop_tick(drop_tick), .level_up(level_up), .level(level),
    .period(period), .running(running), .paused(paused)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every observed tick must match the oldest expected cycle
  task automatic mon();
    if (tick_chk) begin
      if (drop_tick) begin
        if (exp_q.size() == 0) check("unexpected_tick", int'(drop_tick), 0);
        else check("tick_cycle", cyc, exp_q.pop_front());
      end else if (exp_q.size() > 0 && exp_q[0] < cyc) begin
        check("missed_tick", int'(drop_tick), 1);
        void'(exp_q.pop_front());
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    mon();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start(output int s);
    start = 1'b1;
    step();
    start = 1'b0;
    s = cyc;
  endtask

  function automatic int exp_period(input int l);
    int p;
    p = 20 - 4 * l;
    if (p < 6) p = 6;
    return p;
  endfunction

  initial begin
    int s, p, acc, lvl, up, l, add;
    tbl[0]  = '{3'd4, 0, 0, 20};
    tbl[1]  = '{3'd4, 0, 0, 20};
    tbl[2]  = '{3'd4, 1, 1, 16};
    tbl[3]  = '{3'd7, 1, 0, 16};
    tbl[4]  = '{3'd0, 1, 0, 16};
    tbl[5]  = '{3'd4, 2, 1, 12};
    tbl[6]  = '{3'd5, 2, 0, 12};
    tbl[7]  = '{3'd6, 2, 0, 12};
    tbl[8]  = '{3'd2, 3, 1, 8};
    tbl[9]  = '{3'd4, 3, 0, 8};
    tbl[10] = '{3'd4, 3, 0, 8};
    tbl[11] = '{3'd3, 4, 1, 6};

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; pause_toggle = 1'b0;
    soft_drop = 1'b0; lines_valid = 1'b0; lines_add = 3'd0; tick_chk = 1'b1;
    steps(3);
    check("rst_drop_tick", int'(drop_tick), 0);
    check("rst_level_up", int'(level_up), 0);
    check("rst_level", int'(level), 0);
    check("rst_period", int'(period), 20);
    check("rst_running", int'(running), 0);
    check("rst_paused", int'(paused), 0);
    reset_n = 1'b1;
    steps(2);
    check("idle_running", int'(running), 0);

    // Plain run: ticks every 20 cycles from start
    do_start(s);
    check("run_running", int'(running), 1);
    check("run_period", int'(period), 20);
    exp_q.push_back(s + 20); exp_q.push_back(s + 40); exp_q.push_back(s + 60);
    steps(61);
    check("run_q_empty", exp_q.size(), 0);
    check("run_level", int'(level), 0);

    // Soft drop from cnt=10
    do_start(s);
    steps(10);
    soft_drop = 1'b1;
    exp_q.push_back(s + 12); exp_q.push_back(s + 15); exp_q.push_back(s + 18);
    step();
    check("soft_period", int'(period), 3);
    steps(7);
    soft_drop = 1'b0;
    exp_q.push_back(s + 38); exp_q.push_back(s + 58);
    steps(2);
    check("soft_release_period", int'(period), 20);
    steps(39);
    check("soft_q_empty", exp_q.size(), 0);

    // Pause at cnt=7 for 50 cycles with ignored line reports
    do_start(s);
    steps(7);
    pause_toggle = 1'b1;
    step();
    pause_toggle = 1'b0;
    check("pause_paused", int'(paused), 1);
    check("pause_running", int'(running), 0);
    lines_add = 3'd4;
    for (int k = 0; k < 50; k++) begin
      lines_valid = (k % 10 == 0);
      step();
    end
    lines_valid = 1'b0;
    check("pause_level", int'(level), 0);
    check("pause_still_paused", int'(paused), 1);
    pause_toggle = 1'b1;
    step();
    pause_toggle = 1'b0;
    p = cyc;
    check("resume_running", int'(running), 1);
    exp_q.push_back(p + 13);
    steps(20);
    check("resume_q_empty", exp_q.size(), 0);

    // stop and start together while RUN
    do_start(s);
    steps(5);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    check("stopstart_running", int'(running), 0);
    check("stopstart_paused", int'(paused), 0);
    check("stopstart_tick", int'(drop_tick), 0);
    check("stopstart_level", int'(level), 0);
    steps(30);

    // start while PAUSE clears level and counter
    do_start(s);
    tick_chk = 1'b0;
    lines_add = 3'd4;
    for (int k = 0; k < 3; k++) begin
      lines_valid = 1'b1; step(); lines_valid = 1'b0; step();
    end
    check("pre_pause_level", int'(level), 1);
    pause_toggle = 1'b1; step(); pause_toggle = 1'b0;
    check("pre_restart_paused", int'(paused), 1);
    steps(3);
    exp_q.delete();
    tick_chk = 1'b1;
    do_start(s);
    check("restart_running", int'(running), 1);
    check("restart_paused", int'(paused), 0);
    check("restart_level", int'(level), 0);
    exp_q.push_back(s + 20);
    steps(21);
    check("restart_q_empty", exp_q.size(), 0);

    // Table of line reports, then saturation sweep against a small model
    do_start(s);
    tick_chk = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      lines_add = tbl[i].lines; lines_valid = 1'b1;
      step();
      lines_valid = 1'b0;
      check("tbl_level", int'(level), tbl[i].lvl);
      check("tbl_level_up", int'(level_up), tbl[i].up);
      step();
      check("tbl_period", int'(period), tbl[i].per);
      check("tbl_level_up_clear", int'(level_up), 0);
    end
    acc = 1; lvl = 4;
    for (int k = 0; k < 36; k++) begin
      l = (k < 30) ? 4 : int'($urandom_range(0, 7));
      add = (l > 4) ? 4 : l;
      up = 0;
      if (acc + add >= 10) begin
        acc = acc + add - 10;
        if (lvl < 15) begin lvl++; up = 1; end
      end else begin
        acc = acc + add;
      end
      lines_add = 3'(l); lines_valid = 1'b1;
      step();
      lines_valid = 1'b0;
      check("sweep_level", int'(level), lvl);
      check("sweep_level_up", int'(level_up), up);
      step();
      check("sweep_period", int'(period), exp_period(lvl));
    end
    check("level_saturated", int'(level), 15);
    soft_drop = 1'b1; steps(2);
    check("max_soft_period", int'(period), 3);
    soft_drop = 1'b0; steps(2);
    check("max_period", int'(period), 6);

    // Asynchronous reset mid-count at level 3
    do_start(s);
    lines_add = 3'd4; lines_valid = 1'b1;
    steps(8);
    lines_valid = 1'b0;
    step();
    check("pre_reset_level", int'(level), 3);
    steps(3);
    reset_n = 1'b0;
    #1;
    check("async_drop_tick", int'(drop_tick), 0);
    check("async_level_up", int'(level_up), 0);
    check("async_level", int'(level), 0);
    check("async_period", int'(period), 20);
    check("async_running", int'(running), 0);
    check("async_paused", int'(paused), 0);
    exp_q.delete();
    tick_chk = 1'b1;
    steps(3);
    reset_n = 1'b1;
    steps(40);
    check("post_reset_running", int'(running), 0);
    check("post_reset_level", int'(level), 0);
    check("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gravity_tick_scheduler.md
Name: gravity_tick_scheduler

Overview:
- Sequences the falling-piece gravity clock for the Tetris core.
- Owns a programmable period counter and emits a one-cycle drop_tick to the game FSM.
- Period is derived from current level, soft-drop and pause state; level advances from cleared-line reports.
- Replaces fixed-rate tick counters with one run/pause/stop-controlled scheduler.

Parameters:
- CNT_W, 26, width of period counter and period output
- BASE_PERIOD, 2500000, level-0 gravity period in clk cycles
- LEVEL_STEP, 200000, period reduction per level
- MIN_PERIOD, 250000, floor on level period (must be >= 2)
- SOFT_PERIOD, 125000, period while soft_drop held (must be >= 1)
- LINES_PER_LEVEL, 10, cleared lines per level increment
- MAX_LEVEL, 15, saturating level ceiling (fits 4 bits)

Ports:
- clk, in, 1, system clock
- reset_n, in, 1, reset; active-low, asynchronous (one clock, async active-low reset)
- start, in, 1, pulse: begin new game
- stop, in, 1, pulse: end game, return to idle
- pause_toggle, in, 1, pulse: RUN<->PAUSE
- soft_drop, in, 1, level: accelerated gravity
- lines_valid, in, 1, pulse: lines_add valid
- lines_add, in, 3, lines cleared this lock (0..4; values >4 clamped to 4)
- drop_tick, out, 1, one-cycle gravity pulse
- level_up, out, 1, one-cycle pulse when level increments
- level, out, 4, current level
- period, out, CNT_W, currently active period
- running, out, 1, state==RUN
- paused, out, 1, state==PAUSE

Behaviour:
- Reset: state IDLE, cnt=0, level=0, line_acc=0, drop_tick=0, level_up=0, period=BASE_PERIOD, running=0, paused=0.
- States:
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE; else pause_toggle -> PAUSE.
  - PAUSE: stop -> IDLE; else pause_toggle -> RUN.
- Priority when several control pulses coincide: stop > start > pause_toggle. start in RUN/PAUSE restarts the game (back to RUN, clears everything).
- On start: cnt=0, level=0, line_acc=0; first RUN cycle has cnt=0.
- level_period = BASE_PERIOD - level*LEVEL_STEP, computed in CNT_W+4 bits; if the result is < MIN_PERIOD or negative, use MIN_PERIOD.
- period = soft_drop ? min(SOFT_PERIOD, level_period) : level_period. Combinational from registered level and soft_drop; registered output.
- Counter, RUN only:
  - if cnt >= period-1: cnt <= 0 and drop_tick <= 1 next cycle.
  - else cnt++ and drop_tick <= 0.
  - ">=" covers period shrinking mid-count (soft_drop asserted late): tick fires on the next evaluation, no wrap through 2^CNT_W.
- PAUSE: cnt held, drop_tick=0, soft_drop ignored for counting; resumes from held cnt.
- IDLE: cnt=0, drop_tick=0.
- Line accounting, RUN only; ignored in IDLE/PAUSE:
  - sum = line_acc + clamp(lines_add,4).
  - if sum >= LINES_PER_LEVEL: line_acc <= sum - LINES_PER_LEVEL; if level < MAX_LEVEL then level++ and level_up pulses.
  - else line_acc <= sum.
  - At MAX_LEVEL: line_acc keeps wrapping, no level_up.
- New level affects period from the cycle after the increment; cnt is not reset on level change.
- lines_valid coincident with a tick: both take effect independently.
- drop_tick latency: exactly period cycles between consecutive ticks at constant period; first tick period cycles after entering RUN.
- reset_n low mid-game: immediate return to reset values, no tick emitted.

Decomposition:
- Shared package tetris_pkg: state encoding (SCH_IDLE, SCH_RUN, SCH_PAUSE), LEVEL_W=4, LINES_W=3, default period constants.
- One sub-module natural: tick_period_counter (cnt, period compare, enable, clear, tick out). Level/line logic and FSM stay in the top.

Test Plan (BASE_PERIOD=20, LEVEL_STEP=4, MIN_PERIOD=6, SOFT_PERIOD=3, LINES_PER_LEVEL=10, CNT_W=8):
- Reset, start at cycle 0, idle inputs -> running=1 from cycle 1; drop_tick at cycles 20, 40, 60; period=20; level=0.
- Running, soft_drop held from cnt=10 -> period=3; drop_tick on the next cycle (cnt >= 2), then every 3 cycles; release -> 20-cycle spacing resumes.
- lines_valid with lines_add=4 three times -> level=1, level_up one pulse, line_acc=2, period=16. Five levels total -> level 5, period=6 (floor).
- Pause at cnt=7 for 50 cycles -> no drop_tick, no level change on lines_valid; resume -> first tick 13 cycles later.
- stop and start in same cycle while RUN -> IDLE, drop_tick=0, level=0. Separate start while PAUSE -> RUN with cnt=0, level=0.
- Assert reset_n low mid-count with level=3 -> all outputs at reset values asynchronously; after release, no tick until start.
